// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
// Holds the FSM state encodings, the opcode constants and the aluOp
// encodings. The ALU control block imports this package as well.
package multi_cycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_TRAP     = 4'd10
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_R        = 6'b000000;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
    localparam logic [5:0] OP_LW       = 6'b100011;
    localparam logic [5:0] OP_SW       = 6'b101011;
    localparam logic [5:0] OP_BEQ      = 6'b000100;
    localparam logic [5:0] OP_J        = 6'b000010;

    // aluOp encodings seen by the ALU control block
    localparam logic [1:0] ALUOP_FUNCT = 2'b00;  // decode funct field
    localparam logic [1:0] ALUOP_CLX   = 2'b01;  // CLO/CLZ (SPECIAL2)
    localparam logic [1:0] ALUOP_ADD   = 2'b10;  // address / PC+4
    localparam logic [1:0] ALUOP_SUB   = 2'b11;  // BEQ compare

    // ALU B-operand select
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU   = 2'b00;
    localparam logic [1:0] PCSRC_OUT   = 2'b01;
    localparam logic [1:0] PCSRC_JUMP  = 2'b10;

    // True for the opcodes that go through MEM_ADDR
    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch, decode,
// memory, R-type, branch and jump steps, plus a retired-instruction count.
// Optional feature: define MULTI_CYCLE_CTRL_ILLEGAL_TRAP_EN to send unknown
// opcodes to a sticky TRAP state and add the illegalOp output; otherwise
// unknown opcodes behave as NOPs.
// The zero flag is carried for interface completeness only: the branch PC
// update is qualified by zero outside this block.
module multi_cycle_ctrl
    import multi_cycle_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        memReady,
    input  logic        zero,
    output logic        pcWrite,
    output logic        pcWriteCond,
    output logic        irWrite,
    output logic        memRead,
    output logic        memWrite,
    output logic        regWrite,
    output logic        iorD,
    output logic        regDst,
    output logic        memToReg,
    output logic        aluSrcA,
    output logic [1:0]  aluOp,
    output logic [1:0]  aluSrcB,
    output logic [1:0]  pcSource,
    output logic [3:0]  state,
    output logic [15:0] retired
`ifdef MULTI_CYCLE_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic        illegalOp
`endif
);

    state_t      state_reg;
    state_t      state_next;
    logic        special2_reg;
    logic [5:0]  opcode_reg;
    logic [15:0] retired_reg;
    // Low from reset until the first clock edge after reset is released;
    // keeps every control quiet during and just after reset.
    logic        running_reg;

    // State register, special2 flag, latched opcode and run flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_FETCH;
            special2_reg <= 1'b0;
            opcode_reg   <= '0;
            running_reg  <= 1'b0;
        end else begin
            running_reg <= 1'b1;
            state_reg   <= state_next;
            if (state_reg == S_DECODE) begin
                opcode_reg   <= opcode;
                special2_reg <= (opcode == OP_SPECIAL2);
            end else if (state_next == S_FETCH) begin
                special2_reg <= 1'b0;
            end
        end
    end

    // Retired counter: one count per return to FETCH, wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_reg <= '0;
        end else if ((state_reg != S_FETCH) && (state_next == S_FETCH)) begin
            retired_reg <= retired_reg + 16'd1;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (running_reg) begin
            case (state_reg)
                S_FETCH:    if (memReady) state_next = S_DECODE;
                S_DECODE: begin
                    if (is_mem_op(opcode))
                        state_next = S_MEM_ADDR;
                    else if ((opcode == OP_R) || (opcode == OP_SPECIAL2))
                        state_next = S_R_EXEC;
                    else if (opcode == OP_BEQ)
                        state_next = S_BRANCH;
                    else if (opcode == OP_J)
                        state_next = S_JUMP;
                    else
`ifdef MULTI_CYCLE_CTRL_ILLEGAL_TRAP_EN
                        state_next = S_TRAP;
`else
                        state_next = S_FETCH;
`endif
                end
                S_MEM_ADDR: state_next = (opcode_reg == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   if (memReady) state_next = S_MEM_WB;
                S_MEM_WB:   state_next = S_FETCH;
                S_MEM_WR:   if (memReady) state_next = S_FETCH;
                S_R_EXEC:   state_next = S_R_WB;
                S_R_WB:     state_next = S_FETCH;
                S_BRANCH:   state_next = S_FETCH;
                S_JUMP:     state_next = S_FETCH;
                S_TRAP:     state_next = S_TRAP;
                default:    state_next = S_FETCH;
            endcase
        end
    end

    // Output decode from the registered state (FETCH also qualifies the
    // IR/PC write pulse with memReady)
    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        irWrite     = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        regWrite    = 1'b0;
        iorD        = 1'b0;
        regDst      = 1'b0;
        memToReg    = 1'b0;
        aluSrcA     = 1'b0;
        aluOp       = ALUOP_FUNCT;
        aluSrcB     = SRCB_REG;
        pcSource    = PCSRC_ALU;
        if (running_reg) begin
            case (state_reg)
                S_FETCH: begin
                    memRead  = 1'b1;
                    aluSrcB  = SRCB_FOUR;
                    aluOp    = ALUOP_ADD;
                    irWrite  = memReady;
                    pcWrite  = memReady;
                end
                S_DECODE: begin
                    aluSrcB  = SRCB_IMM_SH;
                    aluOp    = ALUOP_ADD;
                end
                S_MEM_ADDR: begin
                    aluSrcA  = 1'b1;
                    aluSrcB  = SRCB_IMM;
                    aluOp    = ALUOP_ADD;
                end
                S_MEM_RD: begin
                    memRead  = 1'b1;
                    iorD     = 1'b1;
                end
                S_MEM_WB: begin
                    regWrite = 1'b1;
                    memToReg = 1'b1;
                end
                S_MEM_WR: begin
                    memWrite = 1'b1;
                    iorD     = 1'b1;
                end
                S_R_EXEC: begin
                    aluSrcA  = 1'b1;
                    aluOp    = special2_reg ? ALUOP_CLX : ALUOP_FUNCT;
                end
                S_R_WB: begin
                    regWrite = 1'b1;
                    regDst   = 1'b1;
                end
                S_BRANCH: begin
                    aluSrcA     = 1'b1;
                    aluOp       = ALUOP_SUB;
                    pcWriteCond = 1'b1;
                    pcSource    = PCSRC_OUT;
                end
                S_JUMP: begin
                    pcWrite  = 1'b1;
                    pcSource = PCSRC_JUMP;
                end
                default: ;
            endcase
        end
    end

    assign state   = state_reg;
    assign retired = retired_reg;

`ifdef MULTI_CYCLE_CTRL_ILLEGAL_TRAP_EN
    assign illegalOp = (state_reg == S_TRAP);
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed testbench for multi_cycle_ctrl. Control outputs are packed into
// one 16-bit word and compared against hand-derived per-state values.
// Word layout: [15]pcWrite [14]pcWriteCond [13]irWrite [12]memRead
// [11]memWrite [10]regWrite [9]iorD [8]regDst [7]memToReg [6]aluSrcA
// [5:4]aluOp [3:2]aluSrcB [1:0]pcSource
module tb_multi_cycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        memReady;
    logic        zero;
    logic        pcWrite, pcWriteCond, irWrite, memRead, memWrite, regWrite;
    logic        iorD, regDst, memToReg, aluSrcA;
    logic [1:0]  aluOp, aluSrcB, pcSource;
    logic [3:0]  state;
    logic [15:0] retired;
`ifdef MULTI_CYCLE_CTRL_ILLEGAL_TRAP_EN
    logic        illegalOp;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    wire [15:0] ctl = {pcWrite, pcWriteCond, irWrite, memRead, memWrite, regWrite,
                       iorD, regDst, memToReg, aluSrcA, aluOp, aluSrcB, pcSource};

    multi_cycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .memReady(memReady), .zero(zero),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .irWrite(irWrite),
        .memRead(memRead), .memWrite(memWrite), .regWrite(regWrite),
        .iorD(iorD), .regDst(regDst), .memToReg(memToReg), .aluSrcA(aluSrcA),
        .aluOp(aluOp), .aluSrcB(aluSrcB), .pcSource(pcSource),
        .state(state), .retired(retired)
`ifdef MULTI_CYCLE_CTRL_ILLEGAL_TRAP_EN
        , .illegalOp(illegalOp)
`endif
    );

    always #5 clk = ~clk;

    // Advance one clock, landing 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; opcode = 6'd0; memReady = 1'b0; zero = 1'b0;
        tick(); tick();
        n_cmp++; if (state !== 4'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
        n_cmp++; if (ctl !== 16'h0000) begin n_bad++; $display("FAIL reset_ctl: got %h want 0000", ctl); end
        n_cmp++; if (retired !== 16'd0) begin n_bad++; $display("FAIL reset_retired: got %h want 0000", retired); end
        reset = 1'b0;
        #2;
        n_cmp++; if (ctl !== 16'h0000) begin n_bad++; $display("FAIL release_quiet: got %h want 0000", ctl); end
        tick();
        n_cmp++; if (state !== 4'd0 || ctl !== 16'h1024) begin n_bad++; $display("FAIL fetch_resume: got state=%0d ctl=%h want 0/1024", state, ctl); end
        tick();
        n_cmp++; if (state !== 4'd0) begin n_bad++; $display("FAIL fetch_stall: got %0d want 0", state); end
    endtask

    task automatic test_lw();
        logic [5:0]  op_t  [6] = '{6'b100011, 6'b100011, 6'b101011, 6'b101011, 6'b101011, 6'b101011};
        logic        mr_t  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0]  st_t  [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        logic [15:0] ctl_t [6] = '{16'hB024, 16'h002C, 16'h0068, 16'h1200, 16'h0480, 16'h1024};
        for (int i = 0; i < 6; i++) begin
            opcode = op_t[i]; memReady = mr_t[i];
            #1;
            n_cmp++;
            if (state !== st_t[i] || ctl !== ctl_t[i]) begin
                n_bad++;
                $display("FAIL lw[%0d]: got state=%0d ctl=%h want %0d/%h", i, state, ctl, st_t[i], ctl_t[i]);
            end
            if (i < 5) tick();
        end
        n_cmp++; if (retired !== 16'd1) begin n_bad++; $display("FAIL lw_retired: got %0d want 1", retired); end
    endtask

    task automatic test_sw_stall();
        logic        mr_t  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0]  st_t  [8] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0};
        logic [15:0] ctl_t [8] = '{16'hB024, 16'h002C, 16'h0068, 16'h0A00, 16'h0A00, 16'h0A00, 16'h0A00, 16'h1024};
        opcode = 6'b101011;
        for (int i = 0; i < 8; i++) begin
            memReady = mr_t[i];
            #1;
            n_cmp++;
            if (state !== st_t[i] || ctl !== ctl_t[i]) begin
                n_bad++;
                $display("FAIL sw[%0d]: got state=%0d ctl=%h want %0d/%h", i, state, ctl, st_t[i], ctl_t[i]);
            end
            if (i < 7) tick();
        end
        n_cmp++; if (retired !== 16'd2) begin n_bad++; $display("FAIL sw_retired: got %0d want 2", retired); end
    endtask

    task automatic test_rtype_special2();
        logic [5:0]  op_t  [9] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000,
                                   6'b011100, 6'b011100, 6'b000000, 6'b000000, 6'b000000};
        logic        mr_t  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0]  st_t  [9] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        logic [15:0] ctl_t [9] = '{16'hB024, 16'h002C, 16'h0040, 16'h0500,
                                   16'hB024, 16'h002C, 16'h0050, 16'h0500, 16'h1024};
        for (int i = 0; i < 9; i++) begin
            opcode = op_t[i]; memReady = mr_t[i];
            #1;
            n_cmp++;
            if (state !== st_t[i] || ctl !== ctl_t[i]) begin
                n_bad++;
                $display("FAIL rtype[%0d]: got state=%0d ctl=%h want %0d/%h", i, state, ctl, st_t[i], ctl_t[i]);
            end
            if (i < 8) tick();
        end
        n_cmp++; if (retired !== 16'd4) begin n_bad++; $display("FAIL rtype_retired: got %0d want 4", retired); end
    endtask

    task automatic test_branch_jump();
        logic [5:0]  op_t  [7] = '{6'b000100, 6'b000100, 6'b000100, 6'b000010, 6'b000010, 6'b000010, 6'b000010};
        logic        mr_t  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0]  st_t  [7] = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd9, 4'd0};
        logic [15:0] ctl_t [7] = '{16'hB024, 16'h002C, 16'h4071, 16'hB024, 16'h002C, 16'h8002, 16'h1024};
        zero = 1'b1;
        for (int i = 0; i < 7; i++) begin
            opcode = op_t[i]; memReady = mr_t[i];
            #1;
            n_cmp++;
            if (state !== st_t[i] || ctl !== ctl_t[i]) begin
                n_bad++;
                $display("FAIL brj[%0d]: got state=%0d ctl=%h want %0d/%h", i, state, ctl, st_t[i], ctl_t[i]);
            end
            if (i < 6) tick();
        end
        zero = 1'b0;
        n_cmp++; if (retired !== 16'd6) begin n_bad++; $display("FAIL brj_retired: got %0d want 6", retired); end
    endtask

    task automatic test_illegal();
`ifdef MULTI_CYCLE_CTRL_ILLEGAL_TRAP_EN
        logic        mr_t  [3] = '{1'b1, 1'b1, 1'b0};
        logic [3:0]  st_t  [3] = '{4'd0, 4'd1, 4'd10};
        logic [15:0] ctl_t [3] = '{16'hB024, 16'h002C, 16'h0000};
`else
        logic        mr_t  [3] = '{1'b1, 1'b1, 1'b0};
        logic [3:0]  st_t  [3] = '{4'd0, 4'd1, 4'd0};
        logic [15:0] ctl_t [3] = '{16'hB024, 16'h002C, 16'h1024};
`endif
        opcode = 6'b111111;
        for (int i = 0; i < 3; i++) begin
            memReady = mr_t[i];
            #1;
            n_cmp++;
            if (state !== st_t[i] || ctl !== ctl_t[i]) begin
                n_bad++;
                $display("FAIL illegal[%0d]: got state=%0d ctl=%h want %0d/%h", i, state, ctl, st_t[i], ctl_t[i]);
            end
            if (i < 2) tick();
        end
`ifdef MULTI_CYCLE_CTRL_ILLEGAL_TRAP_EN
        memReady = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if (state !== 4'd10 || illegalOp !== 1'b1 || ctl !== 16'h0000) begin
                n_bad++;
                $display("FAIL trap_hold[%0d]: got state=%0d illegalOp=%b ctl=%h want 10/1/0000", i, state, illegalOp, ctl);
            end
        end
        n_cmp++; if (retired !== 16'd6) begin n_bad++; $display("FAIL trap_retired: got %0d want 6", retired); end
        memReady = 1'b0;
        reset = 1'b1;
        #1;
        n_cmp++; if (state !== 4'd0 || illegalOp !== 1'b0) begin n_bad++; $display("FAIL trap_reset: got state=%0d illegalOp=%b want 0/0", state, illegalOp); end
        tick();
        reset = 1'b0;
        tick();
        #1;
`else
        n_cmp++; if (retired !== 16'd7) begin n_bad++; $display("FAIL nop_retired: got %0d want 7", retired); end
`endif
    endtask

    task automatic test_reset_midstall();
        logic        mr_t  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0]  st_t  [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3};
        logic [15:0] ctl_t [5] = '{16'hB024, 16'h002C, 16'h0068, 16'h1200, 16'h1200};
        opcode = 6'b100011;
        for (int i = 0; i < 5; i++) begin
            memReady = mr_t[i];
            #1;
            n_cmp++;
            if (state !== st_t[i] || ctl !== ctl_t[i]) begin
                n_bad++;
                $display("FAIL stall[%0d]: got state=%0d ctl=%h want %0d/%h", i, state, ctl, st_t[i], ctl_t[i]);
            end
            if (i < 4) tick();
        end
        #1;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (state !== 4'd0 || ctl !== 16'h0000 || retired !== 16'd0) begin
            n_bad++;
            $display("FAIL async_reset: got state=%0d ctl=%h retired=%0d want 0/0000/0", state, ctl, retired);
        end
        memReady = 1'b1;
        tick();
        n_cmp++; if (regWrite !== 1'b0 || state !== 4'd0) begin n_bad++; $display("FAIL reset_no_wb: got regWrite=%b state=%0d want 0/0", regWrite, state); end
        reset = 1'b0; memReady = 1'b0;
        tick();
        #1;
        n_cmp++; if (ctl !== 16'h1024) begin n_bad++; $display("FAIL stall_resume: got %h want 1024", ctl); end
    endtask

    task automatic test_wrap();
        logic        mr_t  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0]  st_t  [4] = '{4'd0, 4'd1, 4'd9, 4'd0};
        logic [15:0] ctl_t [4] = '{16'hB024, 16'h002C, 16'h8002, 16'h1024};
        force dut.retired_reg = 16'hFFFF;
        #1;
        release dut.retired_reg;
        #1;
        n_cmp++; if (retired !== 16'hFFFF) begin n_bad++; $display("FAIL preload: got %h want ffff", retired); end
        tick();
        opcode = 6'b000010;
        for (int i = 0; i < 4; i++) begin
            memReady = mr_t[i];
            #1;
            n_cmp++;
            if (state !== st_t[i] || ctl !== ctl_t[i]) begin
                n_bad++;
                $display("FAIL wrap[%0d]: got state=%0d ctl=%h want %0d/%h", i, state, ctl, st_t[i], ctl_t[i]);
            end
            if (i < 3) tick();
        end
        n_cmp++; if (retired !== 16'h0000) begin n_bad++; $display("FAIL wrap_retired: got %h want 0000", retired); end
    endtask

    // Memory reads and writes must never overlap, sampled mid-cycle
    always @(negedge clk) begin
        if (memRead === 1'b1 && memWrite === 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL rd_wr_overlap: got memRead=1 memWrite=1 want not both");
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_lw();
        test_sw_stall();
        test_rtype_special2();
        test_branch_jump();
        test_illegal();
        test_reset_midstall();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk input 1 (rising-edge clock); reset input 1 (async, active-high).
REQ-002 SHALL have ports: opcode in 6 (IR[31:26]); memReady in 1 (memory handshake complete); zero in 1 (ALU zero flag).
REQ-003 SHALL have control outputs, each 1 bit: pcWrite, pcWriteCond, irWrite, memRead, memWrite, regWrite, iorD, regDst, memToReg, aluSrcA.
REQ-004 SHALL have output aluOp, 2 bits, feeding the ALU control block: 00 = R-type funct, 01 = CLO/CLZ, 10 = add (LW/SW), 11 = sub (BEQ).
REQ-005 SHALL have outputs aluSrcB 2 (00 = reg B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2), pcSource 2 (00 = ALU, 01 = ALUOut, 10 = jump target), state 4 (debug) and retired 16 (instruction count).

Function
REQ-006 SHALL be a Moore FSM: all control outputs decoded from the registered state only.
REQ-007 SHALL use states FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, TRAP=10.
REQ-008 FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=10, pcSource=00. Hold while memReady=0; on memReady=1, pulse irWrite and pcWrite for that cycle and go to DECODE.
REQ-009 DECODE: aluSrcA=0, aluSrcB=11, aluOp=10. Next state by opcode: 100011/101011 -> MEM_ADDR; 000000 -> R_EXEC; 011100 -> R_EXEC with special2 flag set; 000100 -> BRANCH; 000010 -> JUMP; other -> REQ-018.
REQ-010 special2 flag SHALL be captured in DECODE and cleared on return to FETCH.
REQ-011 MEM_ADDR: aluSrcA=1, aluSrcB=10, aluOp=10. Go to MEM_RD if the latched opcode is LW, else MEM_WR.
REQ-012 MEM_RD: memRead=1, iorD=1. Hold until memReady=1, then go to MEM_WB. MEM_WR: memWrite=1, iorD=1. Hold until memReady=1, then go to FETCH.
REQ-013 MEM_WB: regWrite=1, memToReg=1, regDst=0, then go to FETCH.
REQ-014 R_EXEC: aluSrcA=1, aluSrcB=00, aluOp=01 if special2 else 00, then go to R_WB. R_WB: regWrite=1, regDst=1, memToReg=0, then go to FETCH.
REQ-015 BRANCH: aluSrcA=1, aluSrcB=00, aluOp=11, pcWriteCond=1, pcSource=01, then go to FETCH. pcWrite SHALL be 0; the PC update is gated externally by zero.
REQ-016 JUMP: pcWrite=1, pcSource=10, then go to FETCH.
REQ-017 retired SHALL increment by 1 on each transition into FETCH from a non-FETCH, non-reset state, and SHALL wrap from 0xFFFF to 0x0000.
REQ-018 Unknown opcode SHALL follow REQ-024.
REQ-019 The opcode SHALL be latched in DECODE. Changes to opcode in later states SHALL have no effect.
REQ-020 Unassigned outputs in any state SHALL be 0. memRead and memWrite SHALL never both be 1.

Reset
REQ-021 reset=1 SHALL immediately force state=FETCH, special2=0, latched opcode=0, retired=0, and illegalOp=0 if present.
REQ-022 While in reset, all 1-bit controls SHALL be 0, aluOp=00, aluSrcB=00 and pcSource=00. FETCH outputs SHALL resume on the first clk edge after reset deasserts.
REQ-023 Reset asserted mid-instruction, including during a stall, SHALL abandon the instruction with no regWrite, memWrite or pcWrite pulse.

Configuration
REQ-024 Macro MULTI_CYCLE_CTRL_ILLEGAL_TRAP_EN:
- Defined: unknown opcode -> TRAP. TRAP holds forever with all controls 0. An added output illegalOp (1 bit) is 1 in TRAP. Exit only by reset. retired does not increment.
- Undefined: unknown opcode -> FETCH (NOP). retired increments. No illegalOp port.

Structure
REQ-025 A shared package SHALL hold the state encodings, opcode constants (R, SPECIAL2, LW, SW, BEQ, J) and aluOp encodings, also used by the ALU control block.
REQ-026 The block SHALL be a single module with no sub-modules. Next-state logic and output decode SHALL be separate combinational processes.

Verification
REQ-027 LW (opcode 100011), memReady=1 every cycle -> states 0,1,2,3,4,0; regWrite=1 and memToReg=1 only in state 4; retired 0->1.
REQ-028 SW with memReady low for 3 cycles in MEM_WR -> memWrite held for 4 cycles, no regWrite, then FETCH.
REQ-029 R-type then SPECIAL2 (011100) -> aluOp=00 in the first R_EXEC, 01 in the second; regDst=1 in both R_WB; retired=2.
REQ-030 BEQ -> BRANCH with aluOp=11, pcWriteCond=1, pcSource=01, pcWrite=0; 3 cycles total. J -> JUMP with pcWrite=1, pcSource=10.
REQ-031 Opcode 111111, with and without the macro -> TRAP with illegalOp=1 held for 20 cycles until reset; or return to FETCH with retired+1.
REQ-032 Reset pulsed during a MEM_RD stall -> state=0 asynchronously, retired=0, no regWrite; preload retired=0xFFFF and retire one instruction -> 0x0000.
